// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit: coprocessor-0 trap/return responder.
// Holds Status, Cause and EPC. Accepts synchronous traps and eret from decode,
// stacks the interrupt-enable bits, and issues a registered PC redirect to
// fetch. The pipeline is stalled until fetch accepts the redirect.
// Optional build macro: CP0_TIMER_EN adds Count/Compare and a timer interrupt.
//
// Redirect handshake: redirect_valid is high for the whole REDIRECT state and
// redirect_pc is held stable; the transfer completes on the rising edge where
// redirect_valid and redirect_ready are both 1, after which the FSM is IDLE.
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004,
    parameter logic [31:0] STATUS_RESET = 32'h0000_0701
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        exception_in,
    input  logic [4:0]  cause_in,
    input  logic        eret_in,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] status_out,
    output logic [31:0] epc_out,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        stall_out,
    output logic        timer_irq,
    output logic        dbg_state
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    localparam logic [4:0] EXC_SYSCALL = 5'b01000;
    localparam logic [4:0] EXC_BREAK   = 5'b01001;
    localparam logic [4:0] EXC_TEQ     = 5'b01101;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_status;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;
    logic [31:0] r_redirect_pc;

    logic        w_idle;
    logic        w_mask_ok;
    logic        w_take_exc;
    logic        w_take_tmr;
    logic        w_take_eret;
    logic        w_do_mtc0;
    logic        w_pending;
    logic [31:0] w_cause;
    logic [31:0] w_count;
    logic [31:0] w_compare;

    assign w_idle = (r_state == ST_IDLE);

    // Per-cause mask lookup; unknown codes are never accepted.
    always_comb begin
        w_mask_ok = 1'b0;
        case (cause_in)
            EXC_SYSCALL: w_mask_ok = r_status[8];
            EXC_BREAK:   w_mask_ok = r_status[9];
            EXC_TEQ:     w_mask_ok = r_status[10];
            default:     w_mask_ok = 1'b0;
        endcase
    end

    // Request arbitration: trap > timer > eret > mtc0, only while IDLE.
    assign w_take_exc  = w_idle && exception_in && r_status[0] && w_mask_ok;
    assign w_take_eret = w_idle && eret_in && !w_take_exc && !w_take_tmr;
    assign w_do_mtc0   = w_idle && mtc0_we && !w_take_exc && !w_take_tmr && !eret_in;

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_pending;

    assign w_take_tmr = w_idle && r_pending && r_status[0] && r_status[15] && !w_take_exc;
    assign w_pending  = r_pending;
    assign w_count    = r_count;
    assign w_compare  = r_compare;

    // Free-running counter, reloadable by mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 32'h0;
        end else if (w_do_mtc0 && cp0_addr == ADDR_COUNT) begin
            r_count <= wdata;
        end else begin
            r_count <= r_count + 32'h1;
        end
    end

    // Compare register and pending flag; a Compare write acknowledges the interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_compare <= 32'h0;
            r_pending <= 1'b0;
        end else if (w_do_mtc0 && cp0_addr == ADDR_COMPARE) begin
            r_compare <= wdata;
            r_pending <= 1'b0;
        end else if (r_count == r_compare && r_compare != 32'h0) begin
            r_pending <= 1'b1;
        end
    end
`else
    assign w_take_tmr = 1'b0;
    assign w_pending  = 1'b0;
    assign w_count    = 32'h0;
    assign w_compare  = 32'h0;
`endif

    assign w_cause = {16'h0, w_pending, 8'h0, r_exc_code, 2'b00};

    // CP0 read mux; shows the current (pre-write) register contents.
    always_comb begin
        rdata = 32'h0;
        case (cp0_addr)
            ADDR_STATUS:  rdata = r_status;
            ADDR_CAUSE:   rdata = w_cause;
            ADDR_EPC:     rdata = r_epc;
            ADDR_COUNT:   rdata = w_count;
            ADDR_COMPARE: rdata = w_compare;
            default:      rdata = 32'h0;
        endcase
    end

    // Architectural state updates: trap entry, return, and mtc0 writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status   <= STATUS_RESET;
            r_exc_code <= 5'h0;
            r_epc      <= 32'h0;
        end else if (w_take_exc) begin
            r_epc         <= pc_in;
            r_exc_code    <= cause_in;
            r_status[5:0] <= {r_status[3:0], 2'b00};
        end else if (w_take_tmr) begin
            r_epc         <= pc_in;
            r_exc_code    <= 5'h0;
            r_status[5:0] <= {r_status[3:0], 2'b00};
        end else if (w_take_eret) begin
            r_status[5:0] <= {2'b00, r_status[5:2]};
        end else if (w_do_mtc0) begin
            case (cp0_addr)
                ADDR_STATUS: r_status   <= wdata;
                ADDR_CAUSE:  r_exc_code <= wdata[6:2];
                ADDR_EPC:    r_epc      <= wdata;
                default:     ;
            endcase
        end
    end

    // Redirect target captured on the request edge and held through REDIRECT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_pc <= 32'h0;
        end else if (w_take_exc || w_take_tmr) begin
            r_redirect_pc <= EXC_VECTOR;
        end else if (w_take_eret) begin
            r_redirect_pc <= r_epc;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: enter REDIRECT on any accepted request, leave on ready.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_take_exc || w_take_tmr || w_take_eret) w_state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    assign redirect_valid = (r_state == ST_REDIRECT);
    assign stall_out      = (r_state != ST_IDLE);
    assign redirect_pc    = r_redirect_pc;
    assign status_out     = r_status;
    assign epc_out        = r_epc;
    assign timer_irq      = w_pending;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb_cp0_exception_unit: directed bench for cp0_exception_unit.
module tb_cp0_exception_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        exception_in;
    logic [4:0]  cause_in;
    logic        eret_in;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] status_out;
    logic [31:0] epc_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        stall_out;
    logic        timer_irq;
    logic        dbg_state;

    int errors = 0;
    int checks = 0;

    cp0_exception_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_in          (pc_in),
        .exception_in   (exception_in),
        .cause_in       (cause_in),
        .eret_in        (eret_in),
        .mtc0_we        (mtc0_we),
        .cp0_addr       (cp0_addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .status_out     (status_out),
        .epc_out        (epc_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .stall_out      (stall_out),
        .timer_irq      (timer_irq),
        .dbg_state      (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exception_in = 1'b0;
        eret_in      = 1'b0;
        mtc0_we      = 1'b0;
        cause_in     = 5'h0;
        wdata        = 32'h0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_addr = a;
        wdata    = d;
        mtc0_we  = 1'b1;
        step();
        mtc0_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        pc_in = 32'h0;
        redirect_ready = 1'b0;
        cp0_addr = 5'd13;
        #12;
        checks++;
        if (status_out !== 32'h0000_0701) begin
            errors++; $display("FAIL reset_status got %h exp %h", status_out, 32'h0000_0701);
        end
        checks++;
        if (epc_out !== 32'h0 || rdata !== 32'h0) begin
            errors++; $display("FAIL reset_epc_cause epc %h cause %h exp 0", epc_out, rdata);
        end
        checks++;
        if (redirect_valid !== 1'b0 || stall_out !== 1'b0 || redirect_pc !== 32'h0 || timer_irq !== 1'b0) begin
            errors++; $display("FAIL reset_outputs valid %b stall %b pc %h irq %b exp 0", redirect_valid, stall_out, redirect_pc, timer_irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_syscall();
        pc_in = 32'h0040_0010;
        cause_in = 5'b01000;
        exception_in = 1'b1;
        step();
        exception_in = 1'b0;
        cp0_addr = 5'd13;
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4 || stall_out !== 1'b1) begin
            errors++; $display("FAIL syscall_redirect valid %b pc %h stall %b exp 1 00000004 1", redirect_valid, redirect_pc, stall_out);
        end
        checks++;
        if (epc_out !== 32'h0040_0010 || rdata !== 32'h20) begin
            errors++; $display("FAIL syscall_epc_cause epc %h cause %h exp 00400010 00000020", epc_out, rdata);
        end
        checks++;
        if (status_out !== 32'h0000_0704) begin
            errors++; $display("FAIL syscall_status got %h exp 00000704", status_out);
        end
    endtask

    // Ready held low for three edges: valid must be seen for exactly four cycles.
    task automatic test_redirect_hold();
        int valid_cycles;
        valid_cycles = 1;
        redirect_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eret_in = (i == 0);
            step();
            eret_in = 1'b0;
            if (redirect_valid === 1'b1) valid_cycles++;
        end
        checks++;
        if (redirect_pc !== 32'h4 || status_out !== 32'h0000_0704) begin
            errors++; $display("FAIL eret_in_redirect pc %h status %h exp 00000004 00000704", redirect_pc, status_out);
        end
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        if (redirect_valid === 1'b1) valid_cycles++;
        checks++;
        if (valid_cycles !== 4) begin
            errors++; $display("FAIL redirect_hold_len got %0d exp 4", valid_cycles);
        end
        checks++;
        if (stall_out !== 1'b0 || dbg_state !== 1'b0) begin
            errors++; $display("FAIL redirect_return_idle stall %b state %b exp 0 0", stall_out, dbg_state);
        end
    endtask

    task automatic test_eret();
        eret_in = 1'b1;
        step();
        eret_in = 1'b0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0010 || status_out !== 32'h0000_0701) begin
            errors++; $display("FAIL eret valid %b pc %h status %h exp 1 00400010 00000701", redirect_valid, redirect_pc, status_out);
        end
        redirect_ready = 1'b1;
        step();
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++; $display("FAIL eret_done valid %b exp 0", redirect_valid);
        end
    endtask

    // Status 0x501 clears the break mask bit (bit 9) while keeping syscall and teq.
    task automatic test_mask();
        cp0_addr = 5'd12;
        wdata = 32'h0000_0501;
        mtc0_we = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0000_0701) begin
            errors++; $display("FAIL mtc0_no_bypass got %h exp 00000701", rdata);
        end
        step();
        mtc0_we = 1'b0;
        checks++;
        if (status_out !== 32'h0000_0501) begin
            errors++; $display("FAIL mtc0_status got %h exp 00000501", status_out);
        end
        pc_in = 32'h0000_1000;
        cause_in = 5'b01001;
        exception_in = 1'b1;
        step();
        cause_in = 5'b00101;
        step();
        exception_in = 1'b0;
        checks++;
        if (redirect_valid !== 1'b0 || stall_out !== 1'b0 || epc_out !== 32'h0040_0010) begin
            errors++; $display("FAIL masked_ignored valid %b stall %b epc %h exp 0 0 00400010", redirect_valid, stall_out, epc_out);
        end
        pc_in = 32'h0000_2000;
        cause_in = 5'b01101;
        exception_in = 1'b1;
        step();
        exception_in = 1'b0;
        cp0_addr = 5'd13;
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || rdata !== 32'h34 || epc_out !== 32'h0000_2000 || status_out !== 32'h0000_0504) begin
            errors++; $display("FAIL teq_taken valid %b cause %h epc %h status %h exp 1 00000034 00002000 00000504", redirect_valid, rdata, epc_out, status_out);
        end
        step();
        // IE now 0: an unmasked syscall must be ignored.
        cause_in = 5'b01000;
        exception_in = 1'b1;
        step();
        exception_in = 1'b0;
        checks++;
        if (redirect_valid !== 1'b0 || epc_out !== 32'h0000_2000) begin
            errors++; $display("FAIL ie_off_ignored valid %b epc %h exp 0 00002000", redirect_valid, epc_out);
        end
        eret_in = 1'b1;
        step();
        eret_in = 1'b0;
        step();
        mtc0(5'd12, 32'h0000_0701);
    endtask

    task automatic test_priority();
        pc_in = 32'h0000_3000;
        cause_in = 5'b01000;
        exception_in = 1'b1;
        eret_in = 1'b1;
        cp0_addr = 5'd14;
        wdata = 32'hDEAD_BEEF;
        mtc0_we = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (epc_out !== 32'h0000_3000 || redirect_pc !== 32'h4 || status_out !== 32'h0000_0704) begin
            errors++; $display("FAIL exc_over_mtc0 epc %h pc %h status %h exp 00003000 00000004 00000704", epc_out, redirect_pc, status_out);
        end
        step();
        eret_in = 1'b1;
        cp0_addr = 5'd12;
        wdata = 32'h0;
        mtc0_we = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (status_out !== 32'h0000_0701 || redirect_pc !== 32'h0000_3000) begin
            errors++; $display("FAIL eret_over_mtc0 status %h pc %h exp 00000701 00003000", status_out, redirect_pc);
        end
        step();
    endtask

    task automatic test_regmap();
        mtc0(5'd13, 32'hFFFF_FFFF);
        cp0_addr = 5'd13;
        #1;
        checks++;
        if (rdata !== 32'h0000_007C) begin
            errors++; $display("FAIL cause_write got %h exp 0000007c", rdata);
        end
        mtc0(5'd14, 32'h1234_5678);
        checks++;
        if (epc_out !== 32'h1234_5678) begin
            errors++; $display("FAIL epc_write got %h exp 12345678", epc_out);
        end
        mtc0(5'd5, 32'hA5A5_A5A5);
        cp0_addr = 5'd5;
        #1;
        checks++;
        if (rdata !== 32'h0 || status_out !== 32'h0000_0701 || epc_out !== 32'h1234_5678) begin
            errors++; $display("FAIL unmapped rd %h status %h epc %h exp 0 00000701 12345678", rdata, status_out, epc_out);
        end
`ifndef CP0_TIMER_EN
        cp0_addr = 5'd9;
        #1;
        checks++;
        if (rdata !== 32'h0 || timer_irq !== 1'b0) begin
            errors++; $display("FAIL count_absent rd %h irq %b exp 0 0", rdata, timer_irq);
        end
`endif
    endtask

    task automatic test_reset_mid_redirect();
        redirect_ready = 1'b0;
        pc_in = 32'h0000_4000;
        cause_in = 5'b01001;
        exception_in = 1'b1;
        step();
        exception_in = 1'b0;
        checks++;
        if (redirect_valid !== 1'b1) begin
            errors++; $display("FAIL break_taken valid %b exp 1", redirect_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || stall_out !== 1'b0 || redirect_pc !== 32'h0 || epc_out !== 32'h0 || status_out !== 32'h0000_0701) begin
            errors++; $display("FAIL async_reset valid %b stall %b pc %h epc %h status %h exp 0 0 0 0 00000701", redirect_valid, stall_out, redirect_pc, epc_out, status_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        redirect_ready = 1'b1;
        step();
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        bit seen;
        seen = 1'b0;
        mtc0(5'd12, 32'h0000_8701);
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        pc_in = 32'h0000_5000;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (timer_irq === 1'b1) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL timer_irq_timeout irq %b exp 1", timer_irq);
        end
        step();
        cp0_addr = 5'd13;
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || rdata !== 32'h0000_8000 || epc_out !== 32'h0000_5000 || redirect_pc !== 32'h4) begin
            errors++; $display("FAIL timer_trap valid %b cause %h epc %h pc %h exp 1 00008000 00005000 00000004", redirect_valid, rdata, epc_out, redirect_pc);
        end
        step();
        mtc0(5'd11, 32'd0);
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL compare_clear irq %b exp 0", timer_irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_syscall();
        test_redirect_hold();
        test_eret();
        test_mask();
        test_priority();
        test_regmap();
        test_reset_mid_redirect();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
